// File: rtl/axis_upsizer.sv
// rtl/axis_upsizer.sv - AXI4-Stream width upsizer packing narrow beats into wide words, LS segment first.
module axis_upsizer #(
    parameter int S_DATA_WIDTH = 8,
    parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
    parameter int M_DATA_WIDTH = 32,
    parameter int M_KEEP_WIDTH = M_DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser
);

    localparam int SEG_COUNT = M_DATA_WIDTH / S_DATA_WIDTH;
    localparam int CNT_W     = $clog2(SEG_COUNT);

    if (((M_DATA_WIDTH % S_DATA_WIDTH) != 0) || (SEG_COUNT < 2)) begin : g_param_err
        $error("axis_upsizer: M_DATA_WIDTH must be a multiple (>=2x) of S_DATA_WIDTH");
    end

    logic [M_DATA_WIDTH-1:0] r_acc_data;
    logic [M_KEEP_WIDTH-1:0] r_acc_keep;
    logic [USER_WIDTH-1:0]   r_acc_user;
    logic                    r_acc_last;
    logic [CNT_W-1:0]        r_seg_cnt;
    logic                    r_acc_full;

    logic [M_DATA_WIDTH-1:0] r_out_data;
    logic [M_KEEP_WIDTH-1:0] r_out_keep;
    logic [USER_WIDTH-1:0]   r_out_user;
    logic                    r_out_last;
    logic                    r_out_valid;

    logic                    w_out_free;
    logic                    w_accept;
    logic                    w_complete;
    logic [M_DATA_WIDTH-1:0] w_merge_data;
    logic [M_KEEP_WIDTH-1:0] w_merge_keep;
    logic [USER_WIDTH-1:0]   w_merge_user;

    // Ready depends only on local state, never on m_axis_tready.
    assign s_axis_tready = rst_n && !r_acc_full;
    assign w_out_free    = !r_out_valid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_complete    = (r_seg_cnt == CNT_W'(SEG_COUNT - 1)) || s_axis_tlast;

    // Accumulator lanes above seg_cnt are always zero, so OR-merging is a positional insert.
    assign w_merge_data = r_acc_data | (M_DATA_WIDTH'(s_axis_tdata) << (r_seg_cnt * S_DATA_WIDTH));
    assign w_merge_keep = r_acc_keep | (M_KEEP_WIDTH'(s_axis_tkeep) << (r_seg_cnt * S_KEEP_WIDTH));
    assign w_merge_user = r_acc_user | s_axis_tuser;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_data  <= '0;
            r_acc_keep  <= '0;
            r_acc_user  <= '0;
            r_acc_last  <= 1'b0;
            r_seg_cnt   <= '0;
            r_acc_full  <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_user  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && m_axis_tready) begin
                r_out_valid <= 1'b0;
            end
            if (r_acc_full && w_out_free) begin
                r_out_data  <= r_acc_data;
                r_out_keep  <= r_acc_keep;
                r_out_user  <= r_acc_user;
                r_out_last  <= r_acc_last;
                r_out_valid <= 1'b1;
                r_acc_data  <= '0;
                r_acc_keep  <= '0;
                r_acc_user  <= '0;
                r_acc_last  <= 1'b0;
                r_acc_full  <= 1'b0;
                r_seg_cnt   <= '0;
            end else if (w_accept) begin
                if (w_complete) begin
                    r_seg_cnt <= '0;
                    if (w_out_free) begin
                        r_out_data  <= w_merge_data;
                        r_out_keep  <= w_merge_keep;
                        r_out_user  <= w_merge_user;
                        r_out_last  <= s_axis_tlast;
                        r_out_valid <= 1'b1;
                        r_acc_data  <= '0;
                        r_acc_keep  <= '0;
                        r_acc_user  <= '0;
                        r_acc_last  <= 1'b0;
                    end else begin
                        r_acc_data <= w_merge_data;
                        r_acc_keep <= w_merge_keep;
                        r_acc_user <= w_merge_user;
                        r_acc_last <= s_axis_tlast;
                        r_acc_full <= 1'b1;
                    end
                end else begin
                    r_acc_data <= w_merge_data;
                    r_acc_keep <= w_merge_keep;
                    r_acc_user <= w_merge_user;
                    r_seg_cnt  <= r_seg_cnt + 1'b1;
                end
            end
        end
    end

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = r_out_keep;
    assign m_axis_tuser  = r_out_user;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tvalid = r_out_valid;

endmodule

// File: tb/tb_axis_upsizer.sv
// tb/tb_axis_upsizer.sv - scoreboard bench for axis_upsizer (8-bit in, 32-bit out).
module tb_axis_upsizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic [0:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [0:0]  s_tuser = '0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [0:0]  m_tuser;

    axis_upsizer dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } word_t;

    word_t       sb[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          stalls = 0;
    bit          rand_rdy = 0;

    logic [31:0] cur_data = '0;
    logic [3:0]  cur_keep = '0;
    logic        cur_user = 1'b0;
    int          cur_n = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: gather bytes into a word by position; emit on 4 bytes or tlast.
    task automatic model_accept(input logic [7:0] d, input logic k, input logic l, input logic u);
        word_t w;
        cur_data = cur_data + (32'(d) << (8 * cur_n));
        cur_keep = cur_keep | (4'(k) << cur_n);
        cur_user = cur_user | u;
        cur_n++;
        if (cur_n == 4 || l) begin
            w.data = cur_data; w.keep = cur_keep; w.last = l; w.user = cur_user;
            sb.push_back(w);
            model_clear();
        end
    endtask

    task automatic model_clear();
        cur_data = '0; cur_keep = '0; cur_user = 1'b0; cur_n = 0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic k, input logic l, input logic u);
        int t = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 64'(t), 64'(0));
        if (t > 0) stalls++;
        @(posedge clk);
        model_accept(d, k, l, u);
        #1;
        s_tvalid = 1'b0;
    endtask

    // Monitor: pop on every handshake, and verify output holds steady under backpressure.
    logic        hold = 1'b0;
    logic [37:0] held;
    always @(negedge clk) begin
        word_t e;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) chk("hold_stable", 64'({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}), 64'({1'b1, held}));
            hold = m_tvalid && !m_tready;
            held = {m_tdata, m_tkeep, m_tlast, m_tuser};
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", m_tdata);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", 64'(m_tdata), 64'(e.data));
                    chk("tkeep", 64'(m_tkeep), 64'(e.keep));
                    chk("tlast", 64'(m_tlast), 64'(e.last));
                    chk("tuser", 64'(m_tuser), 64'(e.user));
                end
            end
        end
    end

    always @(posedge clk) if (rand_rdy) begin
        #1 m_tready = 1'($urandom_range(0, 1));
    end

    initial begin
        logic [7:0] b;
        int t;

        #2;
        chk("rst_tvalid", 64'(m_tvalid), 0);
        chk("rst_tdata", 64'(m_tdata), 0);
        chk("rst_tkeep", 64'(m_tkeep), 0);
        chk("rst_tlast", 64'(m_tlast), 0);
        chk("rst_tuser", 64'(m_tuser), 0);
        chk("rst_tready", 64'(s_tready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full word with tlast on 4th byte; valid the cycle after the final accept.
        send_beat(8'h11, 1, 0, 0);
        send_beat(8'h22, 1, 0, 0);
        send_beat(8'h33, 1, 0, 0);
        send_beat(8'h44, 1, 1, 0);
        chk("latency_valid", 64'(m_tvalid), 1);
        chk("latency_data", 64'(m_tdata), 64'h44332211);
        repeat (2) @(posedge clk); #1;

        // Partial flushes, including tlast on segment 0.
        send_beat(8'hAA, 1, 0, 0);
        send_beat(8'hBB, 1, 0, 0);
        send_beat(8'hCC, 1, 1, 0);
        send_beat(8'hDD, 1, 1, 0);
        repeat (2) @(posedge clk); #1;

        // Backpressure: two words stored, then ready drops.
        m_tready = 1'b0;
        for (int i = 1; i <= 8; i++) send_beat(8'(i), 1, 0, 0);
        chk("bp_tready_low", 64'(s_tready), 0);
        chk("bp_first_word", 64'(m_tdata), 64'h04030201);
        repeat (3) @(posedge clk); #1;
        chk("bp_tready_still_low", 64'(s_tready), 0);
        m_tready = 1'b1;
        @(posedge clk); #1;
        chk("bp_tready_back", 64'(s_tready), 1);
        chk("bp_second_word", 64'(m_tdata), 64'h08070605);
        repeat (2) @(posedge clk); #1;

        // tuser OR'd across a frame, then a clean frame.
        send_beat(8'h01, 1, 0, 0);
        send_beat(8'h02, 1, 0, 1);
        send_beat(8'h03, 1, 0, 0);
        send_beat(8'h04, 1, 1, 0);
        send_beat(8'h05, 0, 0, 0);
        send_beat(8'h06, 1, 0, 0);
        send_beat(8'h07, 1, 0, 0);
        send_beat(8'h08, 1, 1, 0);
        repeat (2) @(posedge clk); #1;

        // Asynchronous reset mid-frame discards the partial word.
        send_beat(8'hE1, 1, 0, 0);
        send_beat(8'hE2, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 64'(m_tvalid), 0);
        chk("arst_tready", 64'(s_tready), 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_beat(8'h55, 1, 0, 0);
        send_beat(8'h66, 1, 0, 0);
        send_beat(8'h77, 1, 0, 0);
        send_beat(8'h88, 1, 0, 0);
        chk("post_rst_data", 64'(m_tdata), 64'h88776655);
        chk("post_rst_keep", 64'(m_tkeep), 64'hF);
        repeat (2) @(posedge clk); #1;

        // 64 random bytes, full throughput expected.
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom);
            send_beat(b, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 7) == 0));
        end
        chk("no_input_stalls", 64'(stalls), 0);
        repeat (2) @(posedge clk); #1;

        // Random backpressure and random frame lengths.
        rand_rdy = 1;
        for (int i = 0; i < 200; i++) begin
            b = 8'($urandom);
            send_beat(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                      1'($urandom_range(0, 9) == 0));
        end
        send_beat(8'h5A, 1, 1, 0);
        @(posedge clk);
        rand_rdy = 0;
        #1 m_tready = 1'b1;
        t = 0;
        while ((sb.size() != 0 || m_tvalid) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_sb_empty", 64'(sb.size()), 0);
        chk("drain_tvalid", 64'(m_tvalid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
